relu_pool_stream: RTL

RELU_POOL_STREAM -- requirements
Module: relu_pool_stream

---
 rtl/relu_pool_pkg.sv | 17 +
 rtl/relu_pool_linebuf.sv | 27 ++
 rtl/relu_pool_stream.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/relu_pool_pkg.sv
// Shared FSM encoding, pool-mode constants and sizing helper for the
// ReLU + 2x2 pooling stream block.
package relu_pool_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    // Index width for a buffer of the given depth, never narrower than one bit.
    function automatic int idx_width(int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/relu_pool_linebuf.sv
// Single-port line buffer holding one even-row pair result per column pair,
// with a combinational read at the same index used for writes.
module relu_pool_linebuf
    import relu_pool_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17,
    parameter int IW    = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IW-1:0]    idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/relu_pool_stream.sv
// Streaming ReLU followed by 2x2/stride-2 max or average pooling over a square
// row-major feature map; CHANNELS lanes share one position counter and FSM.
module relu_pool_stream
    import relu_pool_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int CHANNELS = 1,
    parameter int MAX_FMAP = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [5:0]                   fmap_size,
    input  logic                         relu_en,
    input  logic                         avg_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DWIDTH-1:0]   din,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DWIDTH-1:0]   dout,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         cfg_err
);

    localparam int         LB_DEPTH = MAX_FMAP / 2;
    localparam int         IW       = idx_width(LB_DEPTH);
    localparam int         PW       = DWIDTH + 1;
    localparam logic [6:0] MAX_SIZE = 7'(MAX_FMAP);

    logic [1:0]                 state;
    logic [5:0]                 col;
    logic [5:0]                 row;
    logic [5:0]                 size_q;
    logic                       relu_q;
    logic                       avg_q;
    logic                       accept;
    logic                       last_col;
    logic                       last_pix;
    logic                       size_ok;
    logic                       produce;
    logic                       lb_we;
    logic [IW-1:0]              lb_idx;
    logic [CHANNELS*PW-1:0]     lb_wdata;
    logic [CHANNELS*PW-1:0]     lb_rdata;
    logic [CHANNELS*DWIDTH-1:0] pool_res;

    assign busy     = (state != ST_IDLE);
    assign in_ready = (state == ST_RUN) && !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (col == size_q - 6'd1);
    assign last_pix = last_col && (row == size_q - 6'd1);
    assign size_ok  = (fmap_size >= 6'd2) && ({1'b0, fmap_size} <= MAX_SIZE);

    // Odd trailing column/row pixels land on even indices, so they never pair up.
    assign lb_we   = accept && col[0] && !row[0];
    assign produce = accept && col[0] && row[0];
    assign lb_idx  = IW'(col >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            size_q     <= '0;
            relu_q     <= 1'b0;
            avg_q      <= MODE_MAX;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            state  <= ST_RUN;
                            size_q <= fmap_size;
                            relu_q <= relu_en;
                            avg_q  <= avg_mode;
                            col    <= '0;
                            row    <= '0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (last_col) begin
                            col <= '0;
                            row <= row + 6'd1;
                        end else begin
                            col <= col + 6'd1;
                        end
                        if (last_pix) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!out_valid || out_ready) begin
                        state      <= ST_IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        logic signed [DWIDTH-1:0] sample;
        logic signed [DWIDTH-1:0] px;
        logic signed [DWIDTH-1:0] held;
        logic signed [PW-1:0]     pair;
        logic signed [PW-1:0]     lb_rd;
        logic signed [PW:0]       quad;
        logic [DWIDTH-1:0]        res;
        logic                     lane_unused;

        assign sample = din[g*DWIDTH +: DWIDTH];
        assign px     = (relu_q && sample[DWIDTH-1]) ? '0 : sample;
        assign lb_rd  = lb_rdata[g*PW +: PW];

        always_ff @(posedge clk) begin
            if (accept && !col[0]) begin
                held <= px;
            end
        end

        always_comb begin
            pair = {held[DWIDTH-1], held};
            if (avg_q == MODE_AVG) begin
                pair = {held[DWIDTH-1], held} + {px[DWIDTH-1], px};
            end else if (px > held) begin
                pair = {px[DWIDTH-1], px};
            end
        end

        // Dropping the two low bits of the 4-way sum is a floor division by 4.
        always_comb begin
            quad = {lb_rd[PW-1], lb_rd} + {pair[PW-1], pair};
            res  = lb_rd[DWIDTH-1:0];
            if (avg_q == MODE_AVG) begin
                res = quad[PW:2];
            end else if (pair > lb_rd) begin
                res = pair[DWIDTH-1:0];
            end
        end

        assign lane_unused                    = ^quad[1:0];
        assign lb_wdata[g*PW +: PW]           = pair;
        assign pool_res[g*DWIDTH +: DWIDTH]   = res;
    end

    relu_pool_linebuf #(
        .DEPTH (LB_DEPTH),
        .WIDTH (CHANNELS*PW),
        .IW    (IW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .idx   (lb_idx),
        .wdata (lb_wdata),
        .rdata (lb_rdata)
    );

    // New results only arrive while in_ready is high, so the register is never overwritten unread.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
        end else if (produce) begin
            out_valid <= 1'b1;
            dout      <= pool_res;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
